// File: rtl/gcd_sched_pkg.sv
// Shared types and default parameters for the GCD request scheduler.
package gcd_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam int DEF_WIDTH          = 16;
  localparam int DEF_NREQ           = 2;
  localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/gcd_rr_arbiter.sv
// Round-robin pick: first valid requester at or after ptr_i, wrapping; purely combinational.
module gcd_rr_arbiter
  import gcd_sched_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   idx_o,
  output logic            any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_i) + k) % NREQ);
      if (!any_o && valid_i[cand]) begin
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Arbitrates NREQ requesters onto one GCD core; zero operands bypass the core (1-cycle), else LOAD/RUN/RESP.
// Response holds until rsp_ready_i; requests see req_ready_o=0 while busy. GCD_SCHED_TIMEOUT_EN adds a RUN watchdog.
module gcd_sched
  import gcd_sched_pkg::*;
#(
  parameter  int WIDTH          = DEF_WIDTH,
  parameter  int NREQ           = DEF_NREQ,
  parameter  int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int IW             = $clog2(NREQ)
) (
  input  logic                  clk_i,
  input  logic                  nreset_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*WIDTH-1:0] req_a_i,
  input  logic [NREQ*WIDTH-1:0] req_b_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [IW-1:0]         rsp_id_o,
  output logic [WIDTH-1:0]      rsp_gcd_o,
  output logic                  rsp_err_o,
  output logic                  core_load_o,
  output logic [WIDTH-1:0]      core_a_o,
  output logic [WIDTH-1:0]      core_b_o,
  output logic                  core_enable_o,
  input  logic                  core_finish_i,
  input  logic [WIDTH-1:0]      core_result_i,
  output logic                  busy_o
);

  if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
    $error("gcd_sched: NREQ must be in 2..4");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("gcd_sched: TIMEOUT_CYCLES must be positive");
  end

  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign a_arr[g] = req_a_i[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b_i[g*WIDTH +: WIDTH];
  end

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             core_load_q, core_load_d;
  logic             core_enable_q, core_enable_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

`ifdef GCD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  gcd_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
`ifdef GCD_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          gidx_d = arb_idx;
          opa_d  = a_arr[arb_idx];
          opb_d  = b_arr[arb_idx];
`ifdef GCD_SCHED_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          // gcd(x,0) = x and gcd(0,0) = 0, so a zero operand resolves to A|B without the core
          if (a_arr[arb_idx] != '0 && b_arr[arb_idx] != '0) begin
            state_d = S_LOAD;
          end else begin
            res_d   = a_arr[arb_idx] | b_arr[arb_idx];
            state_d = S_RESP;
          end
        end
      end
      S_LOAD: begin
        state_d = S_RUN;
`ifdef GCD_SCHED_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_RUN: begin
        if (core_finish_i) begin
          res_d   = core_result_i;
          state_d = S_RESP;
        end
`ifdef GCD_SCHED_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    rsp_valid_d   = (state_d == S_RESP);
    core_load_d   = (state_d == S_LOAD);
    core_enable_d = (state_d == S_RUN);
    busy_d        = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      gidx_q        <= '0;
      opa_q         <= '0;
      opb_q         <= '0;
      res_q         <= '0;
      rsp_valid_q   <= 1'b0;
      core_load_q   <= 1'b0;
      core_enable_q <= 1'b0;
      busy_q        <= 1'b0;
`ifdef GCD_SCHED_TIMEOUT_EN
      cnt_q         <= '0;
      err_q         <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gidx_q        <= gidx_d;
      opa_q         <= opa_d;
      opb_q         <= opb_d;
      res_q         <= res_d;
      rsp_valid_q   <= rsp_valid_d;
      core_load_q   <= core_load_d;
      core_enable_q <= core_enable_d;
      busy_q        <= busy_d;
`ifdef GCD_SCHED_TIMEOUT_EN
      cnt_q         <= cnt_d;
      err_q         <= err_d;
`endif
    end
  end

  // Accept is combinational so a grant lands in the same cycle; reset forces it low too.
  assign req_ready_o   = (state_q == S_IDLE && nreset_i) ? arb_gnt : '0;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_id_o      = gidx_q;
  assign rsp_gcd_o     = res_q;
  assign core_load_o   = core_load_q;
  assign core_a_o      = opa_q;
  assign core_b_o      = opb_q;
  assign core_enable_o = core_enable_q;
  assign busy_o        = busy_q;
`ifdef GCD_SCHED_TIMEOUT_EN
  assign rsp_err_o     = err_q;
`else
  assign rsp_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched: grant, rotation, bypass, backpressure, reset mid-run, watchdog.
module tb_gcd_sched;

  localparam int WIDTH = 16;
  localparam int NREQ  = 2;

  logic                  clk_i;
  logic                  nreset_i;
  logic [NREQ-1:0]       req_valid_i;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*WIDTH-1:0] req_a_i;
  logic [NREQ*WIDTH-1:0] req_b_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [0:0]            rsp_id_o;
  logic [WIDTH-1:0]      rsp_gcd_o;
  logic                  rsp_err_o;
  logic                  core_load_o;
  logic [WIDTH-1:0]      core_a_o;
  logic [WIDTH-1:0]      core_b_o;
  logic                  core_enable_o;
  logic                  core_finish_i;
  logic [WIDTH-1:0]      core_result_i;
  logic                  busy_o;

  int n_chk = 0;
  int n_err = 0;

  gcd_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT_CYCLES(8)) dut (
    .clk_i         (clk_i),
    .nreset_i      (nreset_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_ready_i   (rsp_ready_i),
    .rsp_id_o      (rsp_id_o),
    .rsp_gcd_o     (rsp_gcd_o),
    .rsp_err_o     (rsp_err_o),
    .core_load_o   (core_load_o),
    .core_a_o      (core_a_o),
    .core_b_o      (core_b_o),
    .core_enable_o (core_enable_o),
    .core_finish_i (core_finish_i),
    .core_result_i (core_result_i),
    .busy_o        (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    nreset_i      = 1'b0;
    req_valid_i   = 2'b11;
    req_a_i       = {16'd12, 16'd48};
    req_b_i       = {16'd8, 16'd18};
    rsp_ready_i   = 1'b0;
    core_finish_i = 1'b0;
    core_result_i = '0;
    #2;
    chk("rst_ready", req_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_load", core_load_o, 0);
    chk("rst_core_a", core_a_o, 0);
    chk("rst_gcd", rsp_gcd_o, 0);

    // Both valid out of reset: ptr=0 picks requester 0
    @(negedge clk_i);
    nreset_i = 1'b1;
    #1;
    chk("first_grant_ready", req_ready_o, 2'b01);
    tick();
    chk("load_pulse", core_load_o, 1);
    chk("load_a", core_a_o, 48);
    chk("load_b", core_b_o, 18);
    chk("load_busy", busy_o, 1);
    chk("load_ready_held", req_ready_o, 0);
    req_valid_i = 2'b10;
    tick();
    chk("run_load_off", core_load_o, 0);
    chk("run_enable", core_enable_o, 1);
    chk("run_no_rsp", rsp_valid_o, 0);
    core_finish_i = 1'b1;
    core_result_i = 16'd6;
    tick();
    chk("rsp0_valid", rsp_valid_o, 1);
    chk("rsp0_id", rsp_id_o, 0);
    chk("rsp0_gcd", rsp_gcd_o, 6);
    chk("rsp0_err", rsp_err_o, 0);
    chk("rsp0_enable_off", core_enable_o, 0);
    core_finish_i = 1'b0;
    core_result_i = '0;

    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", rsp_valid_o, 1);
      chk("bp_gcd", rsp_gcd_o, 6);
      chk("bp_id", rsp_id_o, 0);
      chk("bp_ready", req_ready_o, 0);
      chk("bp_load", core_load_o, 0);
    end

    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("idle_busy", busy_o, 0);
    chk("idle_rsp_valid", rsp_valid_o, 0);
    chk("rr_grant1_ready", req_ready_o, 2'b10);
    // finish raised outside RUN must not short-circuit the core
    core_finish_i = 1'b1;
    core_result_i = 16'd99;
    tick();
    chk("load1_a", core_a_o, 12);
    chk("load1_b", core_b_o, 8);
    chk("load1_pulse", core_load_o, 1);
    chk("load1_no_rsp", rsp_valid_o, 0);
    req_valid_i = 2'b00;
    tick();
    chk("ignore_finish_run", core_enable_o, 1);
    chk("ignore_finish_norsp", rsp_valid_o, 0);
    core_result_i = 16'd4;
    tick();
    chk("rsp1_id", rsp_id_o, 1);
    chk("rsp1_gcd", rsp_gcd_o, 4);
    core_finish_i = 1'b0;
    rsp_ready_i   = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Rotation back to 0, exercised with bypass operands
    req_a_i     = {16'd0, 16'd0};
    req_b_i     = {16'd0, 16'd35};
    req_valid_i = 2'b11;
    #1;
    chk("rot_ready", req_ready_o, 2'b01);
    tick();
    chk("byp_valid", rsp_valid_o, 1);
    chk("byp_id", rsp_id_o, 0);
    chk("byp_gcd", rsp_gcd_o, 35);
    chk("byp_no_load", core_load_o, 0);
    chk("byp_core_a", core_a_o, 0);
    chk("byp_core_b", core_b_o, 35);
    req_valid_i = 2'b10;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("byp2_ready", req_ready_o, 2'b10);
    tick();
    chk("byp00_valid", rsp_valid_o, 1);
    chk("byp00_id", rsp_id_o, 1);
    chk("byp00_gcd", rsp_gcd_o, 0);
    chk("byp00_no_load", core_load_o, 0);
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("byp00_idle", busy_o, 0);

    // Move ptr to 1, then reset in the middle of a RUN
    req_a_i     = {16'd9, 16'd7};
    req_b_i     = {16'd6, 16'd0};
    req_valid_i = 2'b01;
    tick();
    chk("byp7_gcd", rsp_gcd_o, 7);
    req_valid_i = 2'b00;
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    req_a_i     = {16'd9, 16'd9};
    req_b_i     = {16'd6, 16'd6};
    req_valid_i = 2'b10;
    tick();
    chk("pre_rst_load_a", core_a_o, 9);
    req_valid_i = 2'b00;
    tick();
    chk("pre_rst_run", core_enable_o, 1);
    nreset_i = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_enable", core_enable_o, 0);
    chk("mid_rst_core_a", core_a_o, 0);
    chk("mid_rst_rsp_valid", rsp_valid_o, 0);
    chk("mid_rst_id", rsp_id_o, 0);
    req_valid_i = 2'b11;
    #1;
    chk("mid_rst_ready", req_ready_o, 0);
    @(negedge clk_i);
    nreset_i = 1'b1;
    #1;
    chk("post_rst_ptr0", req_ready_o, 2'b01);
    tick();
    chk("post_rst_load", core_load_o, 1);
    req_valid_i = 2'b00;
    tick();
    core_finish_i = 1'b1;
    core_result_i = 16'd3;
    tick();
    chk("post_rst_id", rsp_id_o, 0);
    chk("post_rst_gcd", rsp_gcd_o, 3);
    chk("post_rst_err", rsp_err_o, 0);
    core_finish_i = 1'b0;
    core_result_i = '0;
    rsp_ready_i   = 1'b1;
    tick();
    rsp_ready_i = 1'b0;

    // Core never finishes
    req_a_i     = {16'd5, 16'd5};
    req_b_i     = {16'd10, 16'd10};
    req_valid_i = 2'b10;
    tick();
    req_valid_i = 2'b00;
    tick();
    chk("stall_run", core_enable_o, 1);
`ifdef GCD_SCHED_TIMEOUT_EN
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("to_wait_enable", core_enable_o, 1);
      chk("to_wait_norsp", rsp_valid_o, 0);
    end
    tick();
    chk("to_valid", rsp_valid_o, 1);
    chk("to_err", rsp_err_o, 1);
    chk("to_gcd", rsp_gcd_o, 0);
    chk("to_id", rsp_id_o, 1);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("wait_enable", core_enable_o, 1);
      chk("wait_norsp", rsp_valid_o, 0);
      chk("wait_err", rsp_err_o, 0);
    end
    core_finish_i = 1'b1;
    core_result_i = 16'd5;
    tick();
    chk("late_valid", rsp_valid_o, 1);
    chk("late_gcd", rsp_gcd_o, 5);
    chk("late_err", rsp_err_o, 0);
    core_finish_i = 1'b0;
`endif
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    chk("end_idle", busy_o, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
